// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: shared state encoding and parameter defaults for the PLL reset sequencer
package clk_rst_pkg;
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;
  localparam int STABLE_CYCLES_DEF = 1024;
  localparam int HOLD_CYCLES_DEF   = 64;
  localparam int CE_DIV_DEF        = 2;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit, with synchronous clear
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk)
    if (clr) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies PLL lock, holds the core in reset, then runs with a divided clock enable
module pll_reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int CE_DIV        = CE_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       sys_reset,
  output logic       running,
  output logic       ce,
  output logic [7:0] lock_loss_count,
  output logic [1:0] state_dbg
);
  localparam int MAXC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] div, div_n, lost_n;
  logic locked_s;
  sync_2ff u_sync (
    .clk(clk),
    .clr(rst),
    .d  (pll_locked),
    .q  (locked_s)
  );
  always_comb begin
    state_n = state;
    cnt_n = '0;
    lost_n = lock_loss_count;
    case (state)
      WAIT_LOCK: state_n = locked_s ? STABLE : WAIT_LOCK;
      STABLE:
        if (!locked_s) state_n = WAIT_LOCK;
        else if (cnt == CW'(STABLE_CYCLES - 1)) state_n = HOLD;
        else cnt_n = cnt + 1'b1;
      HOLD:
        if (!locked_s) state_n = WAIT_LOCK;
        else if (cnt == CW'(HOLD_CYCLES - 1)) state_n = RUN;
        else cnt_n = cnt + 1'b1;
      RUN:
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          lost_n = lock_loss_count + 8'(lock_loss_count != 8'hff);
        end
    endcase
    // divider restarts at 0 on the RUN entry edge and wraps every CE_DIV RUN cycles
    div_n = (state != RUN || div == 8'(CE_DIV - 1)) ? 8'd0 : div + 1'b1;
  end
  // outputs are decoded from the next state so they change on the same edge as state
  always_ff @(posedge clk)
    if (rst) begin
      state <= WAIT_LOCK;
      cnt <= '0;
      div <= '0;
      lock_loss_count <= '0;
      sys_reset <= 1'b1;
      running <= 1'b0;
      ce <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      div <= div_n;
      lock_loss_count <= lost_n;
      sys_reset <= state_n != RUN;
      running <= state_n == RUN;
      ce <= state_n == RUN && div_n == 8'(CE_DIV - 1);
    end
  assign state_dbg = state;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: random lock/reset stimulus scored against a run-length model of the sequencer
module tb_pll_reset_sequencer;
  localparam int S = 4;
  localparam int H = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic sys_reset_a, running_a, ce_a, sys_reset_b, running_b, ce_b;
  logic [7:0] llc_a, llc_b;
  logic [1:0] st_a, st_b;
  int checks = 0;
  int failures = 0;
  typedef struct {
    int st;
    int sr;
    int run;
    int ce2;
    int ce1;
    int llc;
  } exp_t;
  exp_t q[$];
  int p1 = 0, p2 = 0, r = 0, llc = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(.STABLE_CYCLES(S), .HOLD_CYCLES(H), .CE_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .sys_reset(sys_reset_a),
    .running(running_a), .ce(ce_a), .lock_loss_count(llc_a), .state_dbg(st_a)
  );
  pll_reset_sequencer #(.STABLE_CYCLES(S), .HOLD_CYCLES(H), .CE_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .sys_reset(sys_reset_b),
    .running(running_b), .ce(ce_b), .lock_loss_count(llc_b), .state_dbg(st_b)
  );

  // r counts consecutive edges that saw synchronized lock; the phase follows from r alone
  always @(posedge clk) begin
    exp_t e;
    int ls, n;
    if (rst) begin
      p1 = 0; p2 = 0; r = 0; llc = 0;
    end else begin
      ls = p2; p2 = p1; p1 = int'(pll_locked);
      if (ls != 0) r = r + 1;
      else begin
        if (r > S + H) llc = (llc < 255) ? llc + 1 : 255;
        r = 0;
      end
    end
    e.st = (r == 0) ? 0 : (r <= S) ? 1 : (r <= S + H) ? 2 : 3;
    e.run = (e.st == 3) ? 1 : 0;
    e.sr = 1 - e.run;
    n = r - (S + H);
    e.ce2 = (e.run == 1 && n % 2 == 0) ? 1 : 0;
    e.ce1 = e.run;
    e.llc = llc;
    q.push_back(e);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", int'(st_a), e.st);
      chk("sys_reset", int'(sys_reset_a), e.sr);
      chk("running", int'(running_a), e.run);
      chk("ce_div2", int'(ce_a), e.ce2);
      chk("lock_loss_count", int'(llc_a), e.llc);
      chk("state_div1", int'(st_b), e.st);
      chk("sys_reset_div1", int'(sys_reset_b), e.sr);
      chk("ce_div1", int'(ce_b), e.ce1);
      chk("llc_div1", int'(llc_b), e.llc);
    end
  end

  task automatic drive(input logic r_v, input logic l_v, input int n);
    rst = r_v;
    pll_locked = l_v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    drive(1, 0, 3);
    drive(0, 1, 20);
    drive(0, 0, 5);
    drive(0, 1, 4);
    drive(0, 0, 3);
    drive(0, 1, 20);
    drive(0, 0, 5);
    drive(0, 1, 20);
    // reset lands on the same edge that synchronized lock falls while in RUN
    drive(0, 0, 2);
    drive(1, 0, 1);
    drive(0, 1, 20);
    for (int i = 0; i < 200; i++)
      drive(logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 2) != 0), int'($urandom_range(1, 12)));
    drive(0, 1, 12);
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 3);
      drive(0, 1, int'($urandom_range(10, 14)));
    end
    drive(0, 1, 3);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
